pipe_ctrl: RTL and testbench

Hazard and stall sequencer for the 5-stage MIPS pipeline. Each cycle it decides whether each pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) holds or loads a bubble. It covers four cases: variable-latency data-RAM accesses in MEM, multi-cycle mul/div in EX, load-use interlocks between ID and EX, and taken-branch flushes. Outputs drive the hold/clear inputs of the stage registers.

---
 rtl/pipe_ctrl_if.sv | 30 +++
 rtl/pipe_ctrl.sv | 120 ++++++++++++
 tb/tb_pipe_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Hazard/stall control bundle between the 5-stage pipeline datapath and pipe_ctrl.
// slave: the sequencer side; master: the datapath (or bench) side.
interface pipe_ctrl_if;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_uses_rs, id_uses_rt;
    logic       ex_rf_we, ex_is_load, ex_md_op, ex_branch_taken;
    logic       mem_access, dram_ack;
    logic       dram_req, md_start, md_busy;
    logic       stall_if, stall_id, stall_ex, stall_mem;
    logic       flush_id, flush_ex, flush_mem, flush_wb;
    logic       mem_timeout;

    modport slave (
        input  id_rs, id_rt, ex_rd, id_uses_rs, id_uses_rt,
               ex_rf_we, ex_is_load, ex_md_op, ex_branch_taken,
               mem_access, dram_ack,
        output dram_req, md_start, md_busy,
               stall_if, stall_id, stall_ex, stall_mem,
               flush_id, flush_ex, flush_mem, flush_wb, mem_timeout
    );

    modport master (
        output id_rs, id_rt, ex_rd, id_uses_rs, id_uses_rt,
               ex_rf_we, ex_is_load, ex_md_op, ex_branch_taken,
               mem_access, dram_ack,
        input  dram_req, md_start, md_busy,
               stall_if, stall_id, stall_ex, stall_mem,
               flush_id, flush_ex, flush_mem, flush_wb, mem_timeout
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Hazard and stall sequencer for the 5-stage pipeline: data-RAM waits, mul/div
// residency, load-use interlock and taken-branch flushes, in that priority.
module pipe_ctrl #(
    parameter int MD_LAT      = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        resetn,
    pipe_ctrl_if.slave  bus
);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam int CW = $clog2(MD_LAT);
    localparam logic [WW-1:0] MT     = WW'(MEM_TIMEOUT);
    localparam logic [CW-1:0] MD_CNT = CW'(MD_LAT - 2);

    typedef enum logic {M_IDLE, M_WAIT} mstate_t;
    typedef enum logic {D_IDLE, D_BUSY} dstate_t;

    mstate_t       mstate_q, mstate_d;
    dstate_t       dstate_q, dstate_d;
    logic [WW-1:0] wcnt_q, wcnt_d, wcnt_eff;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;
    logic          mem_stall, md_stall, md_go, lu;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mstate_q  <= M_IDLE;
            dstate_q  <= D_IDLE;
            wcnt_q    <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            mstate_q  <= mstate_d;
            dstate_q  <= dstate_d;
            wcnt_q    <= wcnt_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Wait count only means something while a wait is in progress.
    always_comb begin
        wcnt_eff  = (mstate_q == M_WAIT) ? wcnt_q : '0;
        mstate_d  = M_IDLE;
        wcnt_d    = '0;
        timeout_d = timeout_q;
        mem_stall = 1'b0;
        if (bus.mem_access && !bus.dram_ack) begin
            if (wcnt_eff < MT) begin
                mem_stall = 1'b1;
                mstate_d  = M_WAIT;
                wcnt_d    = wcnt_eff + WW'(1);
            end else begin
                timeout_d = 1'b1;
            end
        end
    end

    // The counter keeps running under a memory stall but the exit waits for it.
    always_comb begin
        dstate_d = dstate_q;
        cnt_d    = cnt_q;
        md_go    = 1'b0;
        case (dstate_q)
            D_IDLE: if (bus.ex_md_op && !mem_stall) begin
                md_go    = 1'b1;
                cnt_d    = MD_CNT;
                dstate_d = D_BUSY;
            end
            D_BUSY: begin
                if (cnt_q != '0)     cnt_d    = cnt_q - CW'(1);
                else if (!mem_stall) dstate_d = D_IDLE;
            end
            default: dstate_d = D_IDLE;
        endcase
        md_stall = bus.ex_md_op && !(dstate_q == D_BUSY && cnt_q == '0);
    end

    always_comb begin
        lu = bus.ex_is_load && bus.ex_rf_we && (bus.ex_rd != 5'd0) &&
             ((bus.id_uses_rs && bus.id_rs == bus.ex_rd) ||
              (bus.id_uses_rt && bus.id_rt == bus.ex_rd));
    end

    always_comb begin
        bus.dram_req    = 1'b0;
        bus.md_start    = 1'b0;
        bus.md_busy     = 1'b0;
        bus.mem_timeout = 1'b0;
        bus.stall_if    = 1'b0;
        bus.stall_id    = 1'b0;
        bus.stall_ex    = 1'b0;
        bus.stall_mem   = 1'b0;
        bus.flush_id    = 1'b0;
        bus.flush_ex    = 1'b0;
        bus.flush_mem   = 1'b0;
        bus.flush_wb    = 1'b0;
        if (resetn) begin
            bus.dram_req    = bus.mem_access;
            bus.md_start    = md_go;
            bus.md_busy     = (dstate_q == D_BUSY);
            bus.mem_timeout = timeout_q;
            // The bubble goes into the first register downstream of the held ones.
            if (mem_stall) begin
                {bus.stall_if, bus.stall_id, bus.stall_ex, bus.stall_mem} = 4'b1111;
                bus.flush_wb = 1'b1;
            end else if (md_stall) begin
                {bus.stall_if, bus.stall_id, bus.stall_ex} = 3'b111;
                bus.flush_mem = 1'b1;
            end else if (lu) begin
                {bus.stall_if, bus.stall_id} = 2'b11;
                bus.flush_ex = 1'b1;
            end else if (bus.ex_branch_taken) begin
                bus.flush_id = 1'b1;
                bus.flush_ex = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed cases with literal expectations, then random
// traffic checked every cycle against a stall-depth / elapsed-time model.
module tb_pipe_ctrl;
    localparam int MD_LAT = 4;
    localparam int MEM_TIMEOUT = 15;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    pipe_ctrl_if pif();

    pipe_ctrl #(.MD_LAT(MD_LAT), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .resetn(resetn), .bus(pif)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    // model state
    int m_wait = 0, d_elapsed = 0;
    bit m_to = 0, d_started = 0;
    logic [11:0] last;

    // {dram_req, md_start, md_busy, stall_if, stall_id, stall_ex, stall_mem,
    //  flush_id, flush_ex, flush_mem, flush_wb, mem_timeout}
    function automatic logic [11:0] dut_outs();
        return {pif.dram_req, pif.md_start, pif.md_busy, pif.stall_if, pif.stall_id,
                pif.stall_ex, pif.stall_mem, pif.flush_id, pif.flush_ex,
                pif.flush_mem, pif.flush_wb, pif.mem_timeout};
    endfunction

    function automatic bit model_mstall();
        return pif.mem_access && !pif.dram_ack && m_wait < MEM_TIMEOUT;
    endfunction

    function automatic logic [11:0] model_outs();
        bit ms, ds, lu, start;
        int depth;
        logic [3:0] stl, fl;  // index 0..3 = IF,ID,EX,MEM / ID,EX,MEM,WB
        if (!resetn) return '0;
        ms = model_mstall();
        ds = pif.ex_md_op && !(d_started && d_elapsed >= MD_LAT - 1);
        lu = pif.ex_is_load && pif.ex_rf_we && pif.ex_rd != 0 &&
             ((pif.id_uses_rs && pif.id_rs == pif.ex_rd) ||
              (pif.id_uses_rt && pif.id_rt == pif.ex_rd));
        depth = ms ? 4 : ds ? 3 : lu ? 2 : 0;
        start = pif.ex_md_op && !d_started && !ms;
        stl = '0; fl = '0;
        for (int k = 0; k < 4; k++) stl[k] = (k < depth);
        if (depth > 0) fl[depth-1] = 1'b1;
        else if (pif.ex_branch_taken) fl[1:0] = 2'b11;
        return {pif.mem_access, start, d_started, stl[0], stl[1], stl[2], stl[3],
                fl[0], fl[1], fl[2], fl[3], m_to};
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit ms;
        if (!resetn) begin
            m_wait = 0; m_to = 0; d_started = 0; d_elapsed = 0;
            return;
        end
        ms = model_mstall();
        if (pif.mem_access && !pif.dram_ack && m_wait == MEM_TIMEOUT) m_to = 1;
        m_wait = ms ? m_wait + 1 : 0;
        if (!d_started) begin
            if (pif.ex_md_op && !ms) begin d_started = 1; d_elapsed = 1; end
        end else if (d_elapsed >= MD_LAT - 1 && !ms) d_started = 0;
        else d_elapsed++;
    endtask

    // Compare at the falling edge, advance model at the rising edge, drive after.
    task automatic step();
        @(negedge clk);
        last = dut_outs();
        check("model", last, model_outs());
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        pif.id_rs = 0; pif.id_rt = 0; pif.ex_rd = 0;
        pif.id_uses_rs = 0; pif.id_uses_rt = 0; pif.ex_rf_we = 0;
        pif.ex_is_load = 0; pif.ex_md_op = 0; pif.ex_branch_taken = 0;
        pif.mem_access = 0; pif.dram_ack = 0;
    endtask

    localparam logic [11:0] E_MEMSTALL = 12'h9E2;
    localparam logic [11:0] E_DRAMREQ  = 12'h800;

    initial begin
        idle_inputs();
        // reset with activity requested: everything must stay low
        pif.mem_access = 1; pif.ex_md_op = 1;
        step(); check("reset_outs", last, 12'h000);
        step();
        idle_inputs(); resetn = 1;
        step(); check("post_reset_idle", last, 12'h000);

        // load-use on rs, then the same with r0 as destination
        pif.ex_is_load = 1; pif.ex_rf_we = 1; pif.ex_rd = 5; pif.id_uses_rs = 1; pif.id_rs = 5;
        step(); check("load_use", last, 12'h188);
        pif.ex_rd = 0; pif.id_rs = 0;
        step(); check("load_use_r0", last, 12'h000);
        idle_inputs();

        // memory ack after 3 wait cycles
        pif.mem_access = 1;
        for (int i = 0; i < 3; i++) begin step(); check("mem_wait3", last, E_MEMSTALL); end
        pif.dram_ack = 1;
        step(); check("mem_ack", last, E_DRAMREQ);
        idle_inputs();

        // mul/div residency
        pif.ex_md_op = 1;
        step(); check("md_c0", last, 12'h5C4);
        step(); check("md_c1", last, 12'h3C4);
        step(); check("md_c2", last, 12'h3C4);
        step(); check("md_c3", last, 12'h200);
        idle_inputs();
        step(); check("md_done", last, 12'h000);

        // unstalled taken branch
        pif.ex_branch_taken = 1;
        step(); check("branch", last, 12'h018);
        idle_inputs();

        // mul/div under a 5-cycle memory wait, then ack
        pif.ex_md_op = 1; pif.mem_access = 1;
        for (int i = 0; i < 5; i++) begin step(); check("md_memwait", last, E_MEMSTALL); end
        pif.dram_ack = 1;
        for (int i = 0; i < 4; i++) step();
        idle_inputs();
        step();

        // timeout: 15 stall cycles, release on 16th, sticky flag afterwards
        pif.mem_access = 1;
        for (int i = 0; i < MEM_TIMEOUT; i++) begin step(); check("timeout_stall", last, E_MEMSTALL); end
        step(); check("timeout_release", last, E_DRAMREQ);
        pif.mem_access = 0;
        step(); check("timeout_flag", last, 12'h001);
        step(); check("timeout_sticky", last, 12'h001);

        // reset in the middle of a wait
        pif.mem_access = 1;
        step(); step();
        resetn = 0; #1;
        check("reset_mid_wait", dut_outs(), 12'h000);
        step();
        resetn = 1; idle_inputs();
        step(); check("reset_clears_timeout", last, 12'h000);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            resetn = ($urandom_range(0, 199) != 0);
            pif.id_rs = 5'($urandom_range(0, 3));
            pif.id_rt = 5'($urandom_range(0, 3));
            pif.ex_rd = 5'($urandom_range(0, 3));
            pif.id_uses_rs = 1'($urandom_range(0, 1));
            pif.id_uses_rt = 1'($urandom_range(0, 1));
            pif.ex_rf_we = 1'($urandom_range(0, 1));
            pif.ex_is_load = 1'($urandom_range(0, 1));
            pif.ex_md_op = ($urandom_range(0, 3) == 0);
            pif.ex_branch_taken = !pif.ex_md_op && !pif.ex_is_load && ($urandom_range(0, 2) == 0);
            pif.mem_access = 1'($urandom_range(0, 1));
            pif.dram_ack = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
